// File: rtl/alu_exec_unit_if.sv
// Request/result bundle between the ID/EX register and the ALU execute unit.
// master = upstream pipeline, slave = alu_exec_unit.
interface alu_exec_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [1:0]       ALUOp_i;
  logic [5:0]       funct_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic [2:0]       ALUCtrl_o;
  logic             valid_o;
  logic [WIDTH-1:0] data_o;
  logic             zero_o;
  logic             err_o;
  logic             busy_o;

  modport master (
    output valid_i, ALUOp_i, funct_i, data1_i, data2_i,
    input  ready_o, ALUCtrl_o, valid_o, data_o, zero_o, err_o, busy_o
  );

  modport slave (
    input  valid_i, ALUOp_i, funct_i, data1_i, data2_i,
    output ready_o, ALUCtrl_o, valid_o, data_o, zero_o, err_o, busy_o
  );
endinterface

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: ALUOp/funct decode, registered single-cycle ops and an iterative
// MUL_STEP-bits-per-cycle multiplier. Optional SLT support under `ALU_SLT_EN.
module alu_exec_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_STEP = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  alu_exec_unit_if.slave  bus
);

  localparam int unsigned MUL_CYC = WIDTH / MUL_STEP;
  localparam int unsigned CNT_W   = $clog2(MUL_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYC - 1);

`ifdef ALU_SLT_EN
  localparam logic [2:0] UNK_CTRL = 3'b100;
`else
  localparam logic [2:0] UNK_CTRL = 3'b111;
`endif

  typedef enum logic { ST_IDLE, ST_MUL } state_t;
  typedef enum logic [2:0] { OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_SLT, OP_UNK } op_t;

  state_t           state;
  op_t              op;
  logic [2:0]       ctrl;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [CNT_W-1:0] count;
  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic             zero_q;
  logic             err_q;

  // ALUOp/funct decode of the request currently on the bus
  always_comb begin
    op   = OP_UNK;
    ctrl = UNK_CTRL;
    case (bus.ALUOp_i)
      2'b11: begin
        case (bus.funct_i)
          6'b100000: begin op = OP_ADD; ctrl = 3'b010; end
          6'b100010: begin op = OP_SUB; ctrl = 3'b110; end
          6'b100100: begin op = OP_AND; ctrl = 3'b000; end
          6'b100101: begin op = OP_OR;  ctrl = 3'b001; end
          6'b011000: begin op = OP_MUL; ctrl = 3'b011; end
`ifdef ALU_SLT_EN
          6'b101010: begin op = OP_SLT; ctrl = 3'b111; end
`endif
          default:   begin op = OP_UNK; ctrl = UNK_CTRL; end
        endcase
      end
      2'b01:   begin op = OP_SUB; ctrl = 3'b110; end
      2'b00:   begin op = OP_ADD; ctrl = 3'b010; end
      default: begin op = OP_UNK; ctrl = UNK_CTRL; end
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = bus.data1_i + bus.data2_i;
      OP_SUB:  alu_res = bus.data1_i - bus.data2_i;
      OP_AND:  alu_res = bus.data1_i & bus.data2_i;
      OP_OR:   alu_res = bus.data1_i | bus.data2_i;
      OP_SLT:  alu_res = WIDTH'($signed(bus.data1_i) < $signed(bus.data2_i));
      default: alu_res = '0;
    endcase
  end

  // One shift-add step; truncation to WIDTH makes signed and unsigned identical
  assign acc_nxt = acc + (mcand * WIDTH'(mplier[MUL_STEP-1:0]));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      count   <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.valid_i) begin
            if (op == OP_MUL) begin
              mcand  <= bus.data1_i;
              mplier <= bus.data2_i;
              acc    <= '0;
              count  <= '0;
              state  <= ST_MUL;
            end else if (op == OP_UNK) begin
              valid_q <= 1'b1;
              data_q  <= '0;
              zero_q  <= 1'b0;
              err_q   <= 1'b1;
            end else begin
              valid_q <= 1'b1;
              data_q  <= alu_res;
              zero_q  <= (alu_res == '0);
              err_q   <= 1'b0;
            end
          end
        end
        ST_MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << MUL_STEP;
          mplier <= mplier >> MUL_STEP;
          count  <= count + CNT_W'(1);
          if (count == CNT_LAST) begin
            state   <= ST_IDLE;
            valid_q <= 1'b1;
            data_q  <= acc_nxt;
            zero_q  <= (acc_nxt == '0);
            err_q   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready_o   = (state == ST_IDLE);
  assign bus.busy_o    = (state == ST_MUL);
  assign bus.ALUCtrl_o = ctrl;
  assign bus.valid_o   = valid_q;
  assign bus.data_o    = data_q;
  assign bus.zero_o    = zero_q;
  assign bus.err_o     = err_q;

endmodule
